// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop line synchronizer, parity/framing/break detection
// and a first-word fall-through receive FIFO with RTS flow control.
module uart_rx_fifo #(
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_BIT  = 1,
  parameter int unsigned STOP_BITS   = 2,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 Read_Done,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS
);

  localparam int unsigned CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;
  localparam int unsigned WORD_W       = DATA_BITS + 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                 rx_m, rx_s;
  logic [2:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par, par_nxt, frm, frm_nxt, zero, zero_nxt, seen, seen_nxt;
  logic                 tick, wr_en, frm_fin, brk_fin;
  logic [WORD_W-1:0]    word;

  // Sync flops reset low so a held-low line cannot fake a seen-high event.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      frm   <= 1'b0;
      zero  <= 1'b0;
      seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      par   <= par_nxt;
      frm   <= frm_nxt;
      zero  <= zero_nxt;
      seen  <= seen_nxt;
    end
  end

  assign tick = (state == START) ? (cnt == CNT_W'(HALF_BIT - 1))
                                 : (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Frame decoder; zero tracks "every sample so far was low" for break detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? '0 : cnt + CNT_W'(1);
    idx_nxt   = idx;
    shift_nxt = shift;
    par_nxt   = par;
    frm_nxt   = frm;
    zero_nxt  = zero;
    seen_nxt  = seen | rx_s;
    wr_en     = 1'b0;
    frm_fin   = 1'b0;
    brk_fin   = 1'b0;
    word      = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (seen && !rx_s) state_nxt = START;
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
            par_nxt   = 1'b0;
            frm_nxt   = 1'b0;
            zero_nxt  = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          par_nxt   = par ^ rx_s;
          zero_nxt  = zero & ~rx_s;
          if (idx == BIT_W'(DATA_BITS - 1)) begin
            idx_nxt   = '0;
            state_nxt = (PARITY_BIT != 0) ? PARITY : STOP;
          end else begin
            idx_nxt = idx + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_nxt   = par ^ rx_s;
          zero_nxt  = zero & ~rx_s;
          idx_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          frm_fin = frm | ~rx_s;
          brk_fin = (idx == '0) ? (zero & ~rx_s) : zero;
          frm_nxt = frm_fin;
          if (idx == '0) zero_nxt = zero & ~rx_s;
          if (idx == BIT_W'(STOP_BITS - 1)) begin
            wr_en     = 1'b1;
            word      = {brk_fin, frm_fin | brk_fin, par, shift};
            state_nxt = IDLE;
            seen_nxt  = rx_s;
          end else begin
            idx_nxt = idx + BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              pop, push;
  logic [WORD_W-1:0] head_nxt;

  // Head is precomputed from next-cycle pointers so all FIFO outputs are registered.
  always_comb begin
    pop       = Read_Done && (level != '0);
    push      = wr_en && ((level != LVL_W'(FIFO_DEPTH)) || pop);
    rd_nxt    = rd_ptr + PTR_W'(pop);
    level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    if (level_nxt == '0)               head_nxt = '0;
    else if (push && wr_ptr == rd_nxt) head_nxt = word;
    else                               head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge SysClk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      Data_Out      <= '0;
      Rx_Error      <= '0;
      Data_Rdy      <= 1'b0;
      FIFO_Empty    <= 1'b1;
      FIFO_Full     <= 1'b0;
      FIFO_Overflow <= 1'b0;
      RTS           <= 1'b0;
    end else begin
      rd_ptr     <= rd_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      level      <= level_nxt;
      Data_Out   <= head_nxt[DATA_BITS-1:0];
      Rx_Error   <= head_nxt[WORD_W-1:DATA_BITS];
      Data_Rdy   <= (level_nxt != '0);
      FIFO_Empty <= (level_nxt == '0);
      FIFO_Full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
      if (wr_en && !push) FIFO_Overflow <= 1'b1;
      RTS        <= (level_nxt < LVL_W'(FIFO_DEPTH - 1));
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit; a queue model of the
// FIFO is compared against the DUT outputs on every settled cycle.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CPB   = 16;
  localparam int unsigned NBITS = 12;

  logic       clk = 1'b0;
  logic       rst, rx, rd;
  logic [7:0] data_out;
  logic       data_rdy;
  logic [2:0] rx_error;
  logic       fifo_empty, fifo_full, fifo_overflow, rts;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .SYSCLK_RATE(16000000),
    .BAUD_RATE  (1000000)
  ) dut (
    .SysClk       (clk),
    .Rst          (rst),
    .Rx           (rx),
    .Read_Done    (rd),
    .Data_Out     (data_out),
    .Data_Rdy     (data_rdy),
    .Rx_Error     (rx_error),
    .FIFO_Empty   (fifo_empty),
    .FIFO_Full    (fifo_full),
    .FIFO_Overflow(fifo_overflow),
    .RTS          (rts)
  );

  int         vectors    = 0;
  int         miscompares = 0;
  logic [10:0] mq[$];
  logic        m_ovf    = 1'b0;
  logic        check_en = 1'b0;
  logic [7:0]  fd [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line image: bit 0 start, 8:1 data LSB first, 9 parity, 11:10 stops.
  function automatic logic [11:0] mkf(input logic [7:0] d, input logic bad_par,
                                      input logic s1, input logic s2);
    return {s2, s1, (^d) ^ bad_par, d, 1'b0};
  endfunction

  function automatic logic [10:0] decode(input logic [11:0] lb);
    logic [7:0] d;
    logic p, s1, s2, perr, brk, frm;
    d    = lb[8:1];
    p    = lb[9];
    s1   = lb[10];
    s2   = lb[11];
    perr = (^d) ^ p;
    brk  = (d == 8'h00) && !p && !s1;
    frm  = !s1 || !s2 || brk;
    return {brk, frm, perr, d};
  endfunction

  task automatic model_push(input logic [10:0] e);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [10:0] head;
    logic [14:0] exp_v, act_v;
    if (check_en) begin
      head  = (mq.size() != 0) ? mq[0] : 11'h000;
      exp_v = {head[7:0], head[10:8], mq.size() != 0, mq.size() == 0,
               mq.size() == DEPTH, m_ovf, mq.size() < DEPTH - 1};
      act_v = {data_out, rx_error, data_rdy, fifo_empty, fifo_full, fifo_overflow, rts};
      check("cycle{data,err,rdy,empty,full,ovf,rts}", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rd_at >= 0 raises Read_Done for one cycle, sampled at the edge after clock rd_at.
  task automatic send_frame(input logic [11:0] lb, input int rd_at);
    check_en = 1'b0;
    for (int c = 0; c < int'(NBITS * CPB); c++) begin
      @(posedge clk);
      #1;
      rx = lb[c / CPB];
      rd = (c == rd_at);
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
    rd = 1'b0;
    idle(4);
    if (rd_at >= 0 && mq.size() != 0) void'(mq.pop_front());
    model_push(decode(lb));
    check_en = 1'b1;
    idle(3);
  endtask

  task automatic pulse_read();
    check_en = 1'b0;
    @(posedge clk);
    #1;
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_en = 1'b1;
    idle(2);
  endtask

  task automatic do_reset(input int cycles);
    check_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_outputs", 32'({data_out, rx_error, data_rdy, fifo_empty, fifo_full,
                                fifo_overflow, rts}),
          32'({8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("rts_after_reset", 32'(rts), 32'd1);
    check_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    for (int i = 0; i < 10; i++) fd[i] = 8'(8'h1B * (i + 1) + i);

    do_reset(3);
    idle(10);

    // Clean frame, then pop it.
    send_frame(mkf(8'hA5, 1'b0, 1'b1, 1'b1), -1);
    check("a5_data", 32'(data_out), 32'h0000_00A5);
    check("a5_err", 32'(rx_error), 32'd0);
    check("a5_rdy", 32'(data_rdy), 32'd1);
    pulse_read();
    check("a5_popped_empty", 32'(fifo_empty), 32'd1);

    // Parity error, framing error, break.
    send_frame(mkf(8'h3C, 1'b1, 1'b1, 1'b1), -1);
    check("parity_err", 32'(rx_error), 32'b001);
    pulse_read();
    send_frame(mkf(8'h3C, 1'b0, 1'b0, 1'b1), -1);
    check("framing_err", 32'(rx_error), 32'b010);
    check("framing_data", 32'(data_out), 32'h3C);
    pulse_read();
    send_frame(12'h000, -1);
    check("break_word", 32'({rx_error, data_out}), 32'({3'b110, 8'h00}));
    pulse_read();

    // Short low glitch must be rejected; read while empty is ignored.
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_empty", 32'(fifo_empty), 32'd1);
    pulse_read();
    send_frame(mkf(8'h81, 1'b0, 1'b1, 1'b1), -1);
    check("after_glitch_data", 32'(data_out), 32'h81);
    pulse_read();

    // Fill to full, checking RTS and Full thresholds.
    for (int i = 0; i < 8; i++) begin
      send_frame(mkf(fd[i], 1'b0, 1'b1, 1'b1), -1);
      if (i == 6) check("rts_low_at_7", 32'(rts), 32'd0);
      if (i == 6) check("not_full_at_7", 32'(fifo_full), 32'd0);
    end
    check("full_at_8", 32'(fifo_full), 32'd1);
    check("head_frame1", 32'(data_out), 32'(fd[0]));

    // Write while full with a simultaneous pop.
    send_frame(mkf(fd[8], 1'b0, 1'b1, 1'b1), 186);
    check("pop_push_ovf", 32'(fifo_overflow), 32'd0);
    check("pop_push_full", 32'(fifo_full), 32'd1);
    check("pop_push_head", 32'(data_out), 32'(fd[1]));

    // Write while full without a pop: dropped, sticky overflow.
    send_frame(mkf(fd[9], 1'b0, 1'b1, 1'b1), -1);
    check("drop_ovf", 32'(fifo_overflow), 32'd1);
    check("drop_head", 32'(data_out), 32'(fd[1]));

    for (int i = 0; i < 7; i++) pulse_read();
    check("last_entry_frame9", 32'(data_out), 32'(fd[8]));
    pulse_read();
    check("drained_empty", 32'(fifo_empty), 32'd1);
    check("ovf_still_sticky", 32'(fifo_overflow), 32'd1);

    // Reset in the middle of a frame with the line held low.
    send_frame(mkf(8'h77, 1'b0, 1'b1, 1'b1), -1);
    check_en = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(40);
    do_reset(2);
    idle(100);
    check("low_after_reset_empty", 32'(fifo_empty), 32'd1);
    rx = 1'b1;
    idle(10);
    send_frame(mkf(8'h5A, 1'b0, 1'b1, 1'b1), -1);
    check("post_reset_frame", 32'({rx_error, data_out}), 32'({3'b000, 8'h5A}));
    pulse_read();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
